float_adder_pair_driver: RTL and testbench

//  Synthesizable initiator for the float adder stb/ack protocol. Buffers operand pairs from a host stream,

---
 rtl/float_adder_pair_driver.sv | 258 +++++++++++++++++++++++++
 tb/tb_float_adder_pair_driver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_adder_pair_driver.sv
// Buffers host operand pairs and issues each pair to an accurate (bit0) and an approximate (bit1) adder
// over stb/ack, then emits one record per pair. Define FLOAT_DRV_CMP_EN to enable the acc/apx compare.
module float_adder_pair_driver #(
    parameter int DEPTH          = 4,
    parameter int NAB            = 20,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pair_a,
    input  logic [31:0] pair_b,
    input  logic        pair_valid,
    output logic        pair_ready,
    output logic [31:0] dut_a,
    output logic [31:0] dut_b,
    output logic [1:0]  dut_a_stb,
    input  logic [1:0]  dut_a_ack,
    output logic [1:0]  dut_b_stb,
    input  logic [1:0]  dut_b_ack,
    input  logic [31:0] z_acc,
    input  logic [31:0] z_apx,
    input  logic [1:0]  z_stb,
    output logic [1:0]  z_ack,
    output logic [31:0] rec_a,
    output logic [31:0] rec_b,
    output logic [31:0] rec_acc,
    output logic [31:0] rec_apx,
    output logic [1:0]  rec_flags,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [31:0] pair_cnt,
    output logic [31:0] mismatch_cnt,
    output logic        busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef FLOAT_DRV_CMP_EN
    localparam logic CMP_EN = 1'b1;
`else
    localparam logic CMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_COLLECT = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    function automatic logic results_differ(input logic [31:0] acc, input logic [31:0] apx);
        logic [31:0] diff;
        diff = (acc ^ apx) >> NAB;
        return (diff != 32'd0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     mem_a_q [DEPTH];
    logic [31:0]     mem_b_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pair_ready_q, pair_ready_d;
    logic [31:0]     dut_a_q, dut_a_d, dut_b_q, dut_b_d;
    logic [1:0]      a_stb_q, a_stb_d, b_stb_q, b_stb_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      cap_q, cap_d;
    logic [31:0]     acc_q, acc_d, apx_q, apx_d;
    logic            timeout_q, timeout_d, mismatch_q, mismatch_d;
    logic            rec_valid_q, rec_valid_d, busy_q, busy_d;
    logic [31:0]     pair_cnt_q, pair_cnt_d, mm_cnt_q, mm_cnt_d;
    logic            push_s, pop_s, abort_s, empty_s, expire_s;
    logic [1:0]      z_ack_s;

    // FIFO pointer/occupancy bookkeeping; pair_ready is the registered not-full flag
    always_comb begin
        push_s       = pair_valid & pair_ready_q;
        empty_s      = (count_q == CW'(0));
        wr_ptr_d     = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        pair_ready_d = (count_d != CW'(DEPTH));
    end

    // FSM next-state, handshakes, capture and counters
    always_comb begin
        state_d    = state_q;
        dut_a_d    = dut_a_q;
        dut_b_d    = dut_b_q;
        a_stb_d    = a_stb_q;
        b_stb_d    = b_stb_q;
        timer_d    = timer_q;
        cap_d      = cap_q;
        acc_d      = acc_q;
        apx_d      = apx_q;
        timeout_d  = timeout_q;
        mismatch_d = mismatch_q;
        pair_cnt_d = pair_cnt_q;
        mm_cnt_d   = mm_cnt_q;
        pop_s      = 1'b0;
        abort_s    = 1'b0;
        z_ack_s    = 2'b00;
        expire_s   = (timer_q >= TW'(TIMEOUT_CYCLES - 1));
        case (state_q)
            S_IDLE: begin
                pop_s = ~empty_s;
            end
            S_ISSUE: begin
                a_stb_d = a_stb_q & ~dut_a_ack;
                b_stb_d = b_stb_q & ~dut_b_ack;
                timer_d = timer_q + TW'(1);
                if ((a_stb_d | b_stb_d) == 2'b00) begin
                    state_d = S_COLLECT;
                end else begin
                    abort_s = expire_s;
                end
            end
            S_COLLECT: begin
                z_ack_s = z_stb & ~cap_q;
                cap_d   = cap_q | z_ack_s;
                acc_d   = z_ack_s[0] ? z_acc : acc_q;
                apx_d   = z_ack_s[1] ? z_apx : apx_q;
                timer_d = timer_q + TW'(1);
                if (cap_d == 2'b11) begin
                    state_d    = S_EMIT;
                    mismatch_d = CMP_EN & results_differ(acc_d, apx_d);
                end else begin
                    abort_s = expire_s;
                end
            end
            S_EMIT: begin
                if (rec_ready) begin
                    state_d    = S_IDLE;
                    pair_cnt_d = sat_inc(pair_cnt_q);
                    mm_cnt_d   = mismatch_q ? sat_inc(mm_cnt_q) : mm_cnt_q;
                    pop_s      = ~empty_s;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort keeps whatever was captured; the unreceived result stays 0 from the pop
        if (abort_s) begin
            a_stb_d    = 2'b00;
            b_stb_d    = 2'b00;
            timeout_d  = 1'b1;
            mismatch_d = 1'b0;
            state_d    = S_EMIT;
        end else begin
            timeout_d = timeout_q;
        end

        if (pop_s) begin
            dut_a_d    = mem_a_q[rd_ptr_q];
            dut_b_d    = mem_b_q[rd_ptr_q];
            a_stb_d    = 2'b11;
            b_stb_d    = 2'b11;
            timer_d    = TW'(0);
            cap_d      = 2'b00;
            acc_d      = 32'd0;
            apx_d      = 32'd0;
            timeout_d  = 1'b0;
            mismatch_d = 1'b0;
            state_d    = S_ISSUE;
        end else begin
            cap_d = cap_d;
        end

        rec_valid_d = (state_d == S_EMIT);
        busy_d      = (state_d != S_IDLE) || (count_d != CW'(0));
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= 32'd0;
                mem_b_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            mem_a_q[wr_ptr_q] <= pair_a;
            mem_b_q[wr_ptr_q] <= pair_b;
        end
    end

    // State, handshake and record registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= PW'(0);
            rd_ptr_q     <= PW'(0);
            count_q      <= CW'(0);
            pair_ready_q <= 1'b1;
            dut_a_q      <= 32'd0;
            dut_b_q      <= 32'd0;
            a_stb_q      <= 2'b00;
            b_stb_q      <= 2'b00;
            timer_q      <= TW'(0);
            cap_q        <= 2'b00;
            acc_q        <= 32'd0;
            apx_q        <= 32'd0;
            timeout_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            rec_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            pair_cnt_q   <= 32'd0;
            mm_cnt_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pair_ready_q <= pair_ready_d;
            dut_a_q      <= dut_a_d;
            dut_b_q      <= dut_b_d;
            a_stb_q      <= a_stb_d;
            b_stb_q      <= b_stb_d;
            timer_q      <= timer_d;
            cap_q        <= cap_d;
            acc_q        <= acc_d;
            apx_q        <= apx_d;
            timeout_q    <= timeout_d;
            mismatch_q   <= mismatch_d;
            rec_valid_q  <= rec_valid_d;
            busy_q       <= busy_d;
            pair_cnt_q   <= pair_cnt_d;
            mm_cnt_q     <= mm_cnt_d;
        end
    end

    assign pair_ready   = pair_ready_q;
    assign dut_a        = dut_a_q;
    assign dut_b        = dut_b_q;
    assign dut_a_stb    = a_stb_q;
    assign dut_b_stb    = b_stb_q;
    assign z_ack        = z_ack_s;
    assign rec_a        = dut_a_q;
    assign rec_b        = dut_b_q;
    assign rec_acc      = acc_q;
    assign rec_apx      = apx_q;
    assign rec_flags    = {timeout_q, mismatch_q};
    assign rec_valid    = rec_valid_q;
    assign pair_cnt     = pair_cnt_q;
    assign mismatch_cnt = mm_cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_float_adder_pair_driver.sv
// Directed bench for float_adder_pair_driver: two stb/ack adder responders, a record scoreboard,
// and hand-computed expectations for normal, compare, backpressure, timeout, skew and reset cases.
module tb_float_adder_pair_driver;
`ifdef FLOAT_DRV_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic        clk, rst_n;
    logic [31:0] pair_a, pair_b;
    logic        pair_valid, pair_ready;
    logic [31:0] dut_a, dut_b;
    logic [1:0]  dut_a_stb, dut_a_ack, dut_b_stb, dut_b_ack;
    logic [31:0] z_acc, z_apx;
    logic [1:0]  z_stb, z_ack;
    logic [31:0] rec_a, rec_b, rec_acc, rec_apx;
    logic [1:0]  rec_flags;
    logic        rec_valid, rec_ready;
    logic [31:0] pair_cnt, mismatch_cnt;
    logic        busy;

    float_adder_pair_driver #(.DEPTH(4), .NAB(20), .TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .pair_a(pair_a), .pair_b(pair_b), .pair_valid(pair_valid), .pair_ready(pair_ready),
        .dut_a(dut_a), .dut_b(dut_b),
        .dut_a_stb(dut_a_stb), .dut_a_ack(dut_a_ack), .dut_b_stb(dut_b_stb), .dut_b_ack(dut_b_ack),
        .z_acc(z_acc), .z_apx(z_apx), .z_stb(z_stb), .z_ack(z_ack),
        .rec_a(rec_a), .rec_b(rec_b), .rec_acc(rec_acc), .rec_apx(rec_apx),
        .rec_flags(rec_flags), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .pair_cnt(pair_cnt), .mismatch_cnt(mismatch_cnt), .busy(busy)
    );

    int n_tests, n_fail;
    int a_dly[2], b_dly[2], z_dly[2];
    bit z_en[2];
    bit z_mode;
    logic [31:0] z_fix[2];
    bit hold_ready;
    int viol;
    logic [31:0] q_a[$], q_b[$], q_acc[$], q_apx[$];
    logic [1:0]  q_fl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_default();
        for (int i = 0; i < 2; i++) begin
            a_dly[i] = 0; b_dly[i] = 0; z_dly[i] = 0; z_en[i] = 1'b1;
            z_fix[i] = 32'h4040_0000;
        end
        z_mode = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eacc, input logic [31:0] eapx, input logic [1:0] efl);
        int w;
        w = 0;
        pair_a = a; pair_b = b; pair_valid = 1'b1;
        while (!pair_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("push_wait", 32'(w < 500), 32'd1);
        q_a.push_back(a); q_b.push_back(b); q_acc.push_back(eacc); q_apx.push_back(eapx);
        q_fl.push_back(efl);
        @(negedge clk);
        pair_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while ((q_a.size() != 0 || busy) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(w < 1000), 32'd1);
    endtask

    // Adder responders: ack after a_dly/b_dly cycles, return z after z_dly cycles
    initial begin
        bit got_a[2], got_b[2], z_done[2], prev_stb[2];
        int a_cnt[2], b_cnt[2], z_cnt[2];
        logic [31:0] op_a[2], op_b[2];
        logic [1:0] a_hs, b_hs, z_hs;
        logic [31:0] zv;
        dut_a_ack = 2'b00; dut_b_ack = 2'b00; z_stb = 2'b00; z_acc = 32'd0; z_apx = 32'd0;
        a_hs = 2'b00; b_hs = 2'b00; z_hs = 2'b00;
        for (int i = 0; i < 2; i++) begin
            got_a[i] = 1'b0; got_b[i] = 1'b0; z_done[i] = 1'b0; prev_stb[i] = 1'b0;
            a_cnt[i] = 0; b_cnt[i] = 0; z_cnt[i] = 0; op_a[i] = 32'd0; op_b[i] = 32'd0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    dut_a_ack[i] = 1'b0; dut_b_ack[i] = 1'b0; z_stb[i] = 1'b0;
                    got_a[i] = 1'b0; got_b[i] = 1'b0; z_done[i] = 1'b0;
                    a_cnt[i] = 0; b_cnt[i] = 0; z_cnt[i] = 0;
                end else begin
                    if (a_hs[i]) begin got_a[i] = 1'b1; dut_a_ack[i] = 1'b0; end
                    if (b_hs[i]) begin got_b[i] = 1'b1; dut_b_ack[i] = 1'b0; end
                    if (z_hs[i]) begin z_done[i] = 1'b1; z_stb[i] = 1'b0; end
                    if (dut_a_stb[i] && !prev_stb[i]) begin
                        got_a[i] = 1'b0; got_b[i] = 1'b0; z_done[i] = 1'b0; z_stb[i] = 1'b0;
                        dut_a_ack[i] = 1'b0; dut_b_ack[i] = 1'b0;
                        a_cnt[i] = 0; b_cnt[i] = 0; z_cnt[i] = 0;
                        op_a[i] = dut_a; op_b[i] = dut_b;
                    end
                    if (dut_a_stb[i] && !got_a[i] && !dut_a_ack[i]) begin
                        if (a_cnt[i] >= a_dly[i]) dut_a_ack[i] = 1'b1;
                        else a_cnt[i]++;
                    end
                    if (dut_b_stb[i] && !got_b[i] && !dut_b_ack[i]) begin
                        if (b_cnt[i] >= b_dly[i]) dut_b_ack[i] = 1'b1;
                        else b_cnt[i]++;
                    end
                    if (got_a[i] && got_b[i] && !z_done[i] && !z_stb[i] && z_en[i]) begin
                        if (z_cnt[i] >= z_dly[i]) begin
                            zv = z_mode ? (op_a[i] ^ op_b[i]) : z_fix[i];
                            if (i == 0) z_acc = zv;
                            else z_apx = zv;
                            z_stb[i] = 1'b1;
                        end else begin
                            z_cnt[i]++;
                        end
                    end
                end
                prev_stb[i] = dut_a_stb[i];
            end
            #1;
            a_hs = dut_a_ack & dut_a_stb;
            b_hs = dut_b_ack & dut_b_stb;
            z_hs = z_stb & z_ack;
        end
    end

    // Record consumer and scoreboard
    initial begin
        rec_ready = 1'b0;
        forever begin
            @(negedge clk);
            rec_ready = !hold_ready;
            if (rst_n && rec_valid && rec_ready) begin
                chk("rec_expected", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    chk("rec_a", rec_a, q_a.pop_front());
                    chk("rec_b", rec_b, q_b.pop_front());
                    chk("rec_acc", rec_acc, q_acc.pop_front());
                    chk("rec_apx", rec_apx, q_apx.pop_front());
                    chk("rec_flags", 32'(rec_flags), 32'(q_fl.pop_front()));
                end
            end
        end
    end

    // Operand stability while any strobe is outstanding
    initial begin
        logic [31:0] pa, pb;
        bit pstb;
        pa = 32'd0; pb = 32'd0; pstb = 1'b0; viol = 0;
        forever begin
            @(negedge clk);
            if (rst_n && pstb && ((dut_a_stb | dut_b_stb) != 2'b00) && (dut_a != pa || dut_b != pb))
                viol++;
            pstb = ((dut_a_stb | dut_b_stb) != 2'b00);
            pa = dut_a; pb = dut_b;
        end
    end

    initial begin
        logic [31:0] ta, tbv;
        int w, n;
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; pair_valid = 1'b0; pair_a = 32'd0; pair_b = 32'd0; hold_ready = 1'b0;
        cfg_default();
        cyc(3);
        chk("rst_pair_ready", 32'(pair_ready), 32'd1);
        chk("rst_rec_valid", 32'(rec_valid), 32'd0);
        chk("rst_stb", 32'({dut_a_stb, dut_b_stb}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pair_cnt", pair_cnt, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // T1 basic pair, both results in the same cycle
        push(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 2'b00);
        drain("t1_drain");
        chk("t1_pair_cnt", pair_cnt, 32'd1);
        chk("t1_mm_cnt", mismatch_cnt, 32'd0);

        // T2 compare within and outside the NAB ignored bits
        z_fix[1] = 32'h4040_0001;
        push(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0001, 2'b00);
        drain("t2a_drain");
        z_fix[1] = 32'h4050_0000;
        push(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4050_0000, CMP ? 2'b01 : 2'b00);
        drain("t2b_drain");
        chk("t2_pair_cnt", pair_cnt, 32'd3);
        chk("t2_mm_cnt", mismatch_cnt, CMP ? 32'd1 : 32'd0);

        // T3 backpressure: 1 in flight + 4 buffered blocks the sixth
        cfg_default();
        z_mode = 1'b1;
        hold_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ta = 32'h3F80_0000 + 32'(k);
            tbv = 32'h4000_0000 + 32'(k << 4);
            push(ta, tbv, ta ^ tbv, ta ^ tbv, 2'b00);
        end
        chk("t3_full", 32'(pair_ready), 32'd0);
        cyc(10);
        chk("t3_still_full", 32'(pair_ready), 32'd0);
        chk("t3_held", 32'(rec_valid), 32'd1);
        hold_ready = 1'b0;
        ta = 32'h3F80_0005;
        tbv = 32'h4000_0050;
        push(ta, tbv, ta ^ tbv, ta ^ tbv, 2'b00);
        drain("t3_drain");
        chk("t3_pair_cnt", pair_cnt, 32'd9);

        // T4 approximate result never arrives: timeout record after 16 cycles
        cfg_default();
        z_fix[0] = 32'h3F00_0000;
        z_en[1] = 1'b0;
        push(32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000, 32'd0, 2'b10);
        w = 0;
        while (dut_a_stb == 2'b00 && w < 20) begin cyc(1); w++; end
        n = 0;
        while (!rec_valid && n < 100) begin cyc(1); n++; end
        chk("t4_latency", 32'(n), 32'd16);
        chk("t4_flags", 32'(rec_flags), 32'd2);
        chk("t4_z_ack", 32'(z_ack), 32'd0);
        drain("t4_drain");
        z_en[1] = 1'b1;
        z_fix[1] = 32'h3F00_0000;
        push(32'h4040_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000, 2'b00);
        drain("t4_next_drain");
        chk("t4_pair_cnt", pair_cnt, 32'd11);

        // T5 skewed acks, approximate result before accurate
        cfg_default();
        a_dly[0] = 1; b_dly[1] = 7; z_dly[0] = 9;
        z_fix[0] = 32'h4120_0000; z_fix[1] = 32'h4120_0003;
        viol = 0;
        push(32'h40A0_0000, 32'h4000_0000, 32'h4120_0000, 32'h4120_0003, 2'b00);
        drain("t5_drain");
        chk("t5_stable", 32'(viol), 32'd0);

        // T6 reset in COLLECT with pairs still buffered
        cfg_default();
        z_dly[0] = 40;
        push(32'h3F80_0000, 32'h3F80_0000, 32'd0, 32'd0, 2'b00);
        push(32'h4000_0000, 32'h4000_0000, 32'd0, 32'd0, 2'b00);
        push(32'h4040_0000, 32'h4040_0000, 32'd0, 32'd0, 2'b00);
        cyc(4);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_stb", 32'({dut_a_stb, dut_b_stb}), 32'd0);
        chk("t6_z_ack", 32'(z_ack), 32'd0);
        chk("t6_rec_valid", 32'(rec_valid), 32'd0);
        chk("t6_pair_cnt", pair_cnt, 32'd0);
        chk("t6_mm_cnt", mismatch_cnt, 32'd0);
        chk("t6_pair_ready", 32'(pair_ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        q_a.delete(); q_b.delete(); q_acc.delete(); q_apx.delete(); q_fl.delete();
        cfg_default();
        pair_a = 32'h1234_5678; pair_b = 32'h9ABC_DEF0; pair_valid = 1'b1;
        cyc(2);
        pair_valid = 1'b0;
        rst_n = 1'b1;
        cyc(3);
        chk("t6_fifo_empty", 32'(busy), 32'd0);
        chk("t6_ready_after", 32'(pair_ready), 32'd1);
        push(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 2'b00);
        drain("t6_drain");
        chk("t6_pair_cnt_after", pair_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
